// File: rtl/slot_reel_controller.sv
// Three-reel slot machine sequencer: start/stop button handling, tick-driven
// reel advance, result scoring and a timed result hold before returning to idle.
module slot_reel_controller #(
  parameter int unsigned NUM_SYMBOLS       = 10,
  parameter int unsigned SYM_W             = 4,
  parameter int unsigned RESULT_HOLD_TICKS = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_stop,
  output logic [SYM_W-1:0] o_reel0,
  output logic [SYM_W-1:0] o_reel1,
  output logic [SYM_W-1:0] o_reel2,
  output logic [2:0]       o_spinning,
  output logic [2:0]       o_state,
  output logic [1:0]       o_win,
  output logic             o_result_valid
);

  localparam int unsigned SUM_W  = SYM_W + 1;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPIN   = 3'd1,
    S_STOP1  = 3'd2,
    S_STOP2  = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [SYM_W-1:0]  reel0_q, reel0_d;
  logic [SYM_W-1:0]  reel1_q, reel1_d;
  logic [SYM_W-1:0]  reel2_q, reel2_d;
  logic [1:0]        win_q, win_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tick_q, start_q, stop_q;
  logic              tick_ev, start_ev, stop_ev;

  // Modular add computed one bit wider so the sum cannot wrap before the compare.
  function automatic logic [SYM_W-1:0] reel_add(input logic [SYM_W-1:0] r,
                                                input logic [SUM_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, r} + inc;
    if (sum >= SUM_W'(NUM_SYMBOLS)) begin
      sum = sum - SUM_W'(NUM_SYMBOLS);
    end
    return sum[SYM_W-1:0];
  endfunction

  function automatic logic [1:0] score(input logic [SYM_W-1:0] r0,
                                       input logic [SYM_W-1:0] r1,
                                       input logic [SYM_W-1:0] r2);
    if (r0 == r1 && r1 == r2) begin
      return 2'b10;
    end else if (r0 == r1 || r1 == r2 || r0 == r2) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign tick_ev  = i_tick  & ~tick_q;
  assign start_ev = i_start & ~start_q;
  assign stop_ev  = i_stop  & ~stop_q;

  always_comb begin
    o_spinning = 3'b000;
    case (state_q)
      S_SPIN:  o_spinning = 3'b111;
      S_STOP1: o_spinning = 3'b110;
      S_STOP2: o_spinning = 3'b100;
      default: o_spinning = 3'b000;
    endcase
  end

  assign o_result_valid = (state_q == S_RESULT);
  assign o_state        = 3'(state_q);
  assign o_reel0        = reel0_q;
  assign o_reel1        = reel1_q;
  assign o_reel2        = reel2_q;
  assign o_win          = win_q;

  // A reel being stopped on this edge keeps its pre-tick value.
  always_comb begin
    state_d = state_q;
    reel0_d = reel0_q;
    reel1_d = reel1_q;
    reel2_d = reel2_q;
    win_d   = win_q;
    hold_d  = hold_q;

    if (tick_ev && o_spinning[0] && !(stop_ev && state_q == S_SPIN)) begin
      reel0_d = reel_add(reel0_q, SUM_W'(1));
    end
    if (tick_ev && o_spinning[1] && !(stop_ev && state_q == S_STOP1)) begin
      reel1_d = reel_add(reel1_q, SUM_W'(3));
    end
    if (tick_ev && o_spinning[2] && !(stop_ev && state_q == S_STOP2)) begin
      reel2_d = reel_add(reel2_q, SUM_W'(7));
    end

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          state_d = S_SPIN;
          win_d   = 2'b00;
        end
      end
      S_SPIN: begin
        if (stop_ev) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (stop_ev) state_d = S_STOP2;
      end
      S_STOP2: begin
        if (stop_ev) begin
          state_d = S_RESULT;
          hold_d  = '0;
          win_d   = score(reel0_q, reel1_q, reel2_q);
        end
      end
      S_RESULT: begin
        if (tick_ev) begin
          if (hold_q == HOLD_W'(RESULT_HOLD_TICKS - 1)) begin
            state_d = S_IDLE;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      reel0_q <= '0;
      reel1_q <= '0;
      reel2_q <= '0;
      win_q   <= 2'b00;
      hold_q  <= '0;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reel0_q <= reel0_d;
      reel1_q <= reel1_d;
      reel2_q <= reel2_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      tick_q  <= i_tick;
      start_q <= i_start;
      stop_q  <= i_stop;
    end
  end

endmodule

// File: doc/slot_reel_controller.md
Name: slot_reel_controller

Overview:
- Sequences the three reels of the slot machine game.
- Reels advance on the slow game tick produced by the clock divider; the tick is a square wave, used edge-detected.
- A player start button begins a spin. Three stop presses freeze the reels left to right.
- The block then scores the result and holds it for display before returning to idle.
- Sits between the button inputs / clock divider and the 7-segment display and score logic.

Parameters:
- NUM_SYMBOLS, 10, symbols per reel; legal range 8..16; reel values run 0..NUM_SYMBOLS-1.
- SYM_W, 4, reel value width; must satisfy 2^SYM_W >= NUM_SYMBOLS.
- RESULT_HOLD_TICKS, 8, number of tick edges RESULT is held before returning to IDLE; legal range 1..255.

Ports:
- i_clock  input  1  system clock (50 MHz).
- i_reset  input  1  asynchronous, active-high reset.
- i_tick  input  1  clock divider square-wave output; each rising edge is one game tick.
- i_start  input  1  start button, synchronised level.
- i_stop  input  1  stop button, synchronised level.
- o_reel0  output  SYM_W  reel 0 symbol.
- o_reel1  output  SYM_W  reel 1 symbol.
- o_reel2  output  SYM_W  reel 2 symbol.
- o_spinning  output  3  per-reel spinning flag; bit n is reel n.
- o_state  output  3  FSM state code.
- o_win  output  2  result: 00 none, 01 pair, 10 triple.
- o_result_valid  output  1  high while in RESULT.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all reels=0; o_spinning=000; o_win=00; o_result_valid=0.
  - Hold counter=0; edge-detect history registers=0.
- Edge detection:
  - tick_ev = i_tick & ~tick_d, where tick_d is i_tick registered. start_ev and stop_ev are formed the same way.
  - The action occurs on the clock edge where the input is sampled 1 and the previous sample was 0. Holding a button high produces one event only.
- Reel advance (on tick_ev, spinning reels only):
  - reel0 += 1, reel1 += 3, reel2 += 7.
  - Modulo NUM_SYMBOLS: if sum >= NUM_SYMBOLS, subtract NUM_SYMBOLS. Compute at SYM_W+1 bits so there is no overflow.
  - Stopped reels hold their value.
- States (o_state code):
  - IDLE (0): o_spinning=000.
    - start_ev -> SPIN; o_win<=00 on the same edge.
    - stop_ev is ignored.
    - start_ev and stop_ev on the same cycle: start wins; the stop is discarded.
  - SPIN (1): o_spinning=111. stop_ev -> STOP1; reel0 freezes.
  - STOP1 (2): o_spinning=110. stop_ev -> STOP2; reel1 freezes.
  - STOP2 (3): o_spinning=100. stop_ev -> RESULT; reel2 freezes.
    - o_win is registered on the same edge from the frozen values.
    - Triple (10) if reel0==reel1==reel2; else pair (01) if any two are equal; else none (00).
  - RESULT (4): o_spinning=000; o_result_valid=1.
    - The hold counter clears on entry and increments on each tick_ev.
    - When the RESULT_HOLD_TICKS-th tick_ev occurs -> IDLE.
- Stop vs tick collision: stop_ev and tick_ev on the same cycle -> the reel being stopped does NOT advance; its pre-tick value is frozen. The remaining spinning reels do advance.
- start_ev in SPIN/STOP1/STOP2/RESULT is ignored.
- Reels keep their last values through RESULT and IDLE. A new spin continues from those values; there is no re-seed.
- Codes 5..7 are unreachable; if entered, return to IDLE on the next clock.
- Reset mid-spin or mid-RESULT: immediate return to reset values; no partial result is reported.
- All outputs are registered, except o_spinning and o_result_valid, which are decoded from the state register.

Test Plan:
- Reset release, start, then three stops with no ticks between them -> reels 0,0,0; o_win=10; o_result_valid=1 for exactly 8 tick edges, then o_state=0.
- From reset, with a tick every 4 clocks: start, 3 ticks -> reels 3,9,1.
  - Stop -> reel0=3.
  - 2 ticks -> reel1=5, reel2=5.
  - Stop, then an immediate stop -> reels 3,5,5; o_win=01.
- Continue from 3,5,5: start, 1 tick -> 4,8,2. Stop, stop, stop -> o_win=00.
- Stop and tick rising on the same clock in SPIN, with reels at 3,9,1 -> reel0 stays 3; reel1=2; reel2=8.
- Start held high for 100 clocks, plus a stop press in IDLE -> single transition to SPIN; the stop in IDLE has no effect.
- Assert i_reset during STOP1 mid-clock -> all outputs return to reset values asynchronously, before the next clock edge.
